// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: load port and display drive signals of the BCD display scanner
interface bcd_display_scanner_if;
  logic [7:0] bcd_in;
  logic       load;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;
  logic       frame_start;
  modport master (output bcd_in, load, input seg, an, err, frame_start);
  modport slave (input bcd_in, load, output seg, an, err, frame_start);
endinterface

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: two-digit multiplexed 7-segment driver with frame-aligned updates; BCD_DISPLAY_LZB_EN enables leading-zero blanking
module bcd_display_scanner #(
  parameter int REFRESH_CYCLES = 1000,
  parameter int GAP_CYCLES     = 16
) (
  input logic clk,
  input logic rst,
  bcd_display_scanner_if.slave bus
);
  localparam int MAXC = (REFRESH_CYCLES > GAP_CYCLES) ? REFRESH_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] R_LD = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {S_DIG0, S_GAP0, S_DIG1, S_GAP1} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] shadow, shadow_n, pend;
  logic pend_v, bnd, lz;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction
  // next state, counter reload, frame-boundary shadow value and next display drive
  always_comb begin
    bnd = (state == S_GAP1) && (cnt == '0);
    state_n = (cnt == '0) ? state_t'(state + 2'd1) : state;
    cnt_n = (cnt == '0) ? ((state_n == S_DIG0 || state_n == S_DIG1) ? R_LD : G_LD) : cnt - CW'(1);
    shadow_n = bnd ? (bus.load ? bus.bcd_in : (pend_v ? pend : shadow)) : shadow;
`ifdef BCD_DISPLAY_LZB_EN
    lz = (shadow_n[7:4] == 4'd0);
`else
    lz = 1'b0;
`endif
    an_n = (state_n == S_DIG0) ? 2'b10 : (state_n == S_DIG1 && !lz) ? 2'b01 : 2'b11;
    seg_n = (state_n == S_DIG0) ? dec(shadow_n[3:0]) : (state_n == S_DIG1 && !lz) ? dec(shadow_n[7:4]) : 7'h7F;
  end
  // refresh FSM state and dwell counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_GAP1;
      cnt <= G_LD;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // pending capture (last load wins) and shadow/err update at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 8'h00;
      pend_v <= 1'b0;
      shadow <= 8'h00;
      bus.err <= 1'b0;
    end else begin
      if (bus.load && !bnd) begin
        pend <= bus.bcd_in;
        pend_v <= 1'b1;
      end else if (bnd) pend_v <= 1'b0;
      shadow <= shadow_n;
      if (bnd) bus.err <= (shadow_n[7:4] > 4'd9) | (shadow_n[3:0] > 4'd9);
    end
  end
  // registered display outputs change together with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg <= 7'h7F;
      bus.an <= 2'b11;
      bus.frame_start <= 1'b0;
    end else begin
      bus.seg <= seg_n;
      bus.an <= an_n;
      bus.frame_start <= bnd;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed checks of the display scanner with a 12-cycle frame
module tb_bcd_display_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  bcd_display_scanner_if bus();
  bcd_display_scanner #(.REFRESH_CYCLES(4), .GAP_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.frame_start !== 1'b1 && k < 40);
    n_total++;
    if (bus.frame_start !== 1'b1) $display("FAIL sync: frame_start=%b after %0d cycles, required 1", bus.frame_start, k);
    else n_pass++;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.bcd_in = v;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    n_total++;
    if (bus.an !== 2'b11 || bus.seg !== 7'h7F || bus.err !== 1'b0 || bus.frame_start !== 1'b0) $display("FAIL reset_vals: an=%b seg=%h err=%b fs=%b, required 11 7f 0 0", bus.an, bus.seg, bus.err, bus.frame_start);
    else n_pass++;
    rst = 1'b0;
    step(1);
    n_total++;
    if (bus.frame_start !== 1'b0 || bus.an !== 2'b11) $display("FAIL reset_edge1: fs=%b an=%b, required 0 11", bus.frame_start, bus.an);
    else n_pass++;
    step(1);
    n_total++;
    if (bus.frame_start !== 1'b1 || bus.an !== 2'b10 || bus.seg !== 7'h40 || bus.err !== 1'b0) $display("FAIL reset_edge2: fs=%b an=%b seg=%h err=%b, required 1 10 40 0", bus.frame_start, bus.an, bus.seg, bus.err);
    else n_pass++;
  endtask

  task automatic test_normal();
    logic [1:0] ea;
    logic [6:0] es;
    sync();
    do_load(8'h27);
    sync();
    for (int i = 0; i < 12; i++) begin
      ea = (i < 4) ? 2'b10 : (i < 6) ? 2'b11 : (i < 10) ? 2'b01 : 2'b11;
      es = (i < 4) ? 7'h78 : (i < 6) ? 7'h7F : (i < 10) ? 7'h24 : 7'h7F;
      n_total++;
      if (bus.an !== ea || bus.seg !== es || bus.err !== 1'b0) $display("FAIL normal_c%0d: an=%b seg=%h err=%b, required %b %h 0", i, bus.an, bus.seg, bus.err, ea, es);
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_multi_load();
    sync();
    do_load(8'h11);
    do_load(8'h35);
    sync();
    n_total++;
    if (bus.an !== 2'b10 || bus.seg !== 7'h12) $display("FAIL multi_ones: an=%b seg=%h, required 10 12", bus.an, bus.seg);
    else n_pass++;
    step(6);
    n_total++;
    if (bus.an !== 2'b01 || bus.seg !== 7'h30) $display("FAIL multi_tens: an=%b seg=%h, required 01 30", bus.an, bus.seg);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [1:0] ea;
    logic [6:0] es;
    step(5);
    n_total++;
    if (bus.an !== 2'b11 || bus.frame_start !== 1'b0) $display("FAIL bypass_gap1: an=%b fs=%b, required 11 0", bus.an, bus.frame_start);
    else n_pass++;
    do_load(8'h09);
    n_total++;
    if (bus.frame_start !== 1'b1 || bus.an !== 2'b10 || bus.seg !== 7'h10 || bus.err !== 1'b0) $display("FAIL bypass_ones: fs=%b an=%b seg=%h err=%b, required 1 10 10 0", bus.frame_start, bus.an, bus.seg, bus.err);
    else n_pass++;
    step(6);
`ifdef BCD_DISPLAY_LZB_EN
    ea = 2'b11;
    es = 7'h7F;
`else
    ea = 2'b01;
    es = 7'h40;
`endif
    n_total++;
    if (bus.an !== ea || bus.seg !== es) $display("FAIL bypass_tens: an=%b seg=%h, required %b %h", bus.an, bus.seg, ea, es);
    else n_pass++;
  endtask

  task automatic test_error();
    sync();
    do_load(8'h1C);
    sync();
    n_total++;
    if (bus.an !== 2'b10 || bus.seg !== 7'h3F || bus.err !== 1'b1) $display("FAIL err_ones: an=%b seg=%h err=%b, required 10 3f 1", bus.an, bus.seg, bus.err);
    else n_pass++;
    step(6);
    n_total++;
    if (bus.an !== 2'b01 || bus.seg !== 7'h79) $display("FAIL err_tens: an=%b seg=%h, required 01 79", bus.an, bus.seg);
    else n_pass++;
    do_load(8'h05);
    n_total++;
    if (bus.err !== 1'b1) $display("FAIL err_hold: err=%b, required 1", bus.err);
    else n_pass++;
    sync();
    n_total++;
    if (bus.err !== 1'b0 || bus.seg !== 7'h12) $display("FAIL err_clear: err=%b seg=%h, required 0 12", bus.err, bus.seg);
    else n_pass++;
  endtask

  task automatic test_blanking();
    logic [1:0] ea;
    logic [6:0] es;
    int k;
    step(6);
`ifdef BCD_DISPLAY_LZB_EN
    ea = 2'b11;
    es = 7'h7F;
`else
    ea = 2'b01;
    es = 7'h40;
`endif
    n_total++;
    if (bus.an !== ea || bus.seg !== es) $display("FAIL blank_tens: an=%b seg=%h, required %b %h", bus.an, bus.seg, ea, es);
    else n_pass++;
    k = 6;
    do begin
      @(negedge clk);
      k++;
    end while (bus.frame_start !== 1'b1 && k < 40);
    n_total++;
    if (k !== 12) $display("FAIL blank_period: spacing=%0d, required 12", k);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    sync();
    do_load(8'h1C);
    sync();
    step(6);
    n_total++;
    if (bus.an !== 2'b01 || bus.err !== 1'b1) $display("FAIL rstmid_pre: an=%b err=%b, required 01 1", bus.an, bus.err);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (bus.an !== 2'b11 || bus.seg !== 7'h7F || bus.err !== 1'b0 || bus.frame_start !== 1'b0) $display("FAIL rstmid_async: an=%b seg=%h err=%b fs=%b, required 11 7f 0 0", bus.an, bus.seg, bus.err, bus.frame_start);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    step(1);
    n_total++;
    if (bus.frame_start !== 1'b0 || bus.an !== 2'b11) $display("FAIL rstmid_edge1: fs=%b an=%b, required 0 11", bus.frame_start, bus.an);
    else n_pass++;
    step(1);
    n_total++;
    if (bus.frame_start !== 1'b1 || bus.an !== 2'b10 || bus.seg !== 7'h40 || bus.err !== 1'b0) $display("FAIL rstmid_edge2: fs=%b an=%b seg=%h err=%b, required 1 10 40 0", bus.frame_start, bus.an, bus.seg, bus.err);
    else n_pass++;
  endtask

  task automatic test_random_timing();
    int last;
    sync();
    last = 0;
    for (int c = 1; c <= 120; c++) begin
      bus.load = ($urandom_range(0, 3) == 0);
      bus.bcd_in = 8'($urandom);
      @(negedge clk);
      n_total++;
      if (bus.an === 2'b00) $display("FAIL rand_overlap_c%0d: an=%b, required not 00", c, bus.an);
      else n_pass++;
      if (bus.frame_start === 1'b1) begin
        n_total++;
        if (c - last !== 12) $display("FAIL rand_period_c%0d: spacing=%0d, required 12", c, c - last);
        else n_pass++;
        last = c;
      end
    end
    bus.load = 1'b0;
    n_total++;
    if (last < 108) $display("FAIL rand_frames: last frame_start at %0d, required >= 108", last);
    else n_pass++;
  endtask

  initial begin
    bus.load = 1'b0;
    bus.bcd_in = 8'h00;
    step(3);
    test_reset();
    test_normal();
    test_multi_load();
    test_bypass();
    test_error();
    test_blanking();
    test_reset_mid();
    test_random_timing();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
